// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op encodings and result flag type shared by the ALU pipeline
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    typedef struct packed {
        logic parity;
        logic overflow;
        logic greater;
        logic is_eq;
        logic less;
    } alu_flags_t;

    localparam alu_flags_t FLAGS_ZERO = '0;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath; saturating add/sub when ALU_PIPE_SAT_EN is defined
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             oe,
    output logic [WIDTH-1:0] y,
    output alu_flags_t       flags
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] result;
    logic             ovf;

    // Extra top bit captures carry for add and borrow for sub
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Select the operation result and its overflow indication
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            ALU_ADD: begin
                ovf = sum[WIDTH];
`ifdef ALU_PIPE_SAT_EN
                result = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                result = sum[WIDTH-1:0];
`endif
            end
            ALU_SUB: begin
                ovf = diff[WIDTH];
`ifdef ALU_PIPE_SAT_EN
                result = diff[WIDTH] ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
`else
                result = diff[WIDTH-1:0];
`endif
            end
            ALU_AND: result = a & b;
            default: result = a ^ b;
        endcase
    end

    // Flags describe the beat regardless of oe; only y is masked
    always_comb begin
        flags          = FLAGS_ZERO;
        flags.parity   = ^result;
        flags.overflow = ovf;
        flags.greater  = (a > b);
        flags.is_eq    = (a == b);
        flags.less     = (a < b);
        y              = oe ? result : '0;
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - 2-stage elastic ALU pipeline top; optional saturation via ALU_PIPE_SAT_EN
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             oe,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             parity,
    output logic             overflow,
    output logic             greater,
    output logic             is_eq,
    output logic             less
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [1:0]       s1_op;
    logic             s1_oe;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_y;
    alu_flags_t       s2_flags;

    logic [WIDTH-1:0] core_y;
    alu_flags_t       core_flags;

    logic             s1_load;
    logic             s2_load;
    logic             s2_drain;

    // S2 can take a new beat when empty or when its current beat leaves this cycle
    assign s2_load  = s1_valid && (!s2_valid || out_ready);
    assign s2_drain = s2_valid && out_ready;
    assign in_ready = !rst && (!s1_valid || !s2_valid || out_ready);
    assign s1_load  = in_valid && in_ready;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (s1_a),
        .b     (s1_b),
        .op    (s1_op),
        .oe    (s1_oe),
        .y     (core_y),
        .flags (core_flags)
    );

    // Stage 1: operand register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= ALU_ADD;
            s1_oe    <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_a     <= a;
            s1_b     <= b;
            s1_op    <= op;
            s1_oe    <= oe;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: result register, cleared when empty so idle outputs read zero
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
            s2_flags <= FLAGS_ZERO;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            s2_y     <= core_y;
            s2_flags <= core_flags;
        end else if (s2_drain) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
            s2_flags <= FLAGS_ZERO;
        end
    end

    assign out_valid = s2_valid;
    assign y         = s2_y;
    assign parity    = s2_flags.parity;
    assign overflow  = s2_flags.overflow;
    assign greater   = s2_flags.greater;
    assign is_eq     = s2_flags.is_eq;
    assign less      = s2_flags.less;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe (WIDTH 8 and 16); honours ALU_PIPE_SAT_EN
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  op;
    logic        oe;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  y;
    logic        parity, overflow, greater, is_eq, less;

    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [1:0]  op16;
    logic        oe16;
    logic        out_valid16;
    logic        out_ready16;
    logic [15:0] y16;
    logic        parity16, overflow16, greater16, is_eq16, less16;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [68:0] exp_q[$];
    logic [68:0] got_q[$];
    int          in_cyc_q[$];
    int          out_cyc_q[$];

    logic        last_in_ready;
    logic        last_in_fire;
    logic        last_out_valid;
    logic [68:0] last_out;

`ifdef ALU_PIPE_SAT_EN
    localparam logic [10:0] EXP_ADD = {8'hFF, 1'b0, 1'b1, 1'b1};
    localparam logic [9:0]  EXP_SUB = {8'h00, 1'b1, 1'b1};
`else
    localparam logic [10:0] EXP_ADD = {8'h10, 1'b1, 1'b1, 1'b1};
    localparam logic [9:0]  EXP_SUB = {8'hFE, 1'b1, 1'b1};
`endif

    alu_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .oe        (oe),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .parity    (parity),
        .overflow  (overflow),
        .greater   (greater),
        .is_eq     (is_eq),
        .less      (less)
    );

    alu_pipe #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .op        (op16),
        .oe        (oe16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .y         (y16),
        .parity    (parity16),
        .overflow  (overflow16),
        .greater   (greater16),
        .is_eq     (is_eq16),
        .less      (less16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {y[63:0], parity, overflow, greater, is_eq, less} from plain arithmetic
    function automatic logic [68:0] ref_model(input int w, input logic [63:0] ia, input logic [63:0] ib,
                                              input logic [1:0] iop, input logic ioe);
        logic [63:0] mask;
        logic [63:0] r;
        logic        ovf;
        mask = (64'd1 << w) - 64'd1;
        r    = 64'd0;
        ovf  = 1'b0;
        case (iop)
            2'd0: begin
                ovf = (ia + ib) > mask;
                r   = (ia + ib) & mask;
`ifdef ALU_PIPE_SAT_EN
                if (ovf) r = mask;
`endif
            end
            2'd1: begin
                ovf = ia < ib;
                r   = (ia - ib) & mask;
`ifdef ALU_PIPE_SAT_EN
                if (ovf) r = 64'd0;
`endif
            end
            2'd2: r = ia & ib;
            default: r = ia ^ ib;
        endcase
        return {(ioe ? r : 64'd0), ^r, ovf, ia > ib, ia == ib, ia < ib};
    endfunction

    function automatic logic [68:0] pack8();
        return {56'd0, y, parity, overflow, greater, is_eq, less};
    endfunction

    function automatic logic [68:0] pack16();
        return {48'd0, y16, parity16, overflow16, greater16, is_eq16, less16};
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 4))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic rand_beat();
        a  = pick8();
        b  = ($urandom_range(0, 7) == 0) ? a : pick8();
        op = 2'($urandom_range(0, 3));
        oe = ($urandom_range(0, 3) != 0);
    endtask

    // One clock of the 8-bit DUT: sample handshakes at negedge, return at posedge+1
    task automatic tick();
        @(negedge clk);
        last_in_ready  = in_ready;
        last_in_fire   = in_valid && in_ready;
        last_out_valid = out_valid;
        last_out       = pack8();
        if (rst) begin
            exp_q.delete();
        end else begin
            if (last_in_fire) begin
                exp_q.push_back(ref_model(8, {56'd0, a}, {56'd0, b}, op, oe));
                in_cyc_q.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                got_q.push_back(last_out);
                out_cyc_q.push_back(cyc);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        exp_q.delete();
        got_q.delete();
        in_cyc_q.delete();
        out_cyc_q.delete();
    endtask

    task automatic send_one(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] iop,
                            input logic ioe, output logic [68:0] res, output logic [68:0] expv,
                            output bit ok);
        int n;
        clear_queues();
        a = ia; b = ib; op = iop; oe = ioe;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_in_fire && n < 20);
        in_valid = 1'b0;
        n = 0;
        while (got_q.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        ok   = (got_q.size() != 0) && (exp_q.size() != 0);
        res  = ok ? got_q.pop_front() : 69'd0;
        expv = ok ? exp_q.pop_front() : 69'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready_low: got %b expected 0", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || in_ready16 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready_after: got %b/%b expected 1/1", in_ready, in_ready16);
        end
        n_checks++;
        if (pack8() !== 69'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_zero: got %h expected 0", pack8());
        end
    endtask

    task automatic test_directed();
        logic [68:0] res;
        logic [68:0] expv;
        bit          ok;

        send_one(8'hF0, 8'h20, ALU_ADD, 1'b1, res, expv, ok);
        n_checks++;
        if (!ok || res !== expv) begin
            n_fail++;
            $display("FAIL add_model: got %h expected %h ok=%0d", res, expv, ok);
        end
        n_checks++;
        if ({res[12:5], res[4], res[3], res[2]} !== EXP_ADD) begin
            n_fail++;
            $display("FAIL add_F0_20 {y,par,ovf,gt}: got %h expected %h",
                     {res[12:5], res[4], res[3], res[2]}, EXP_ADD);
        end

        send_one(8'h05, 8'h07, ALU_SUB, 1'b1, res, expv, ok);
        n_checks++;
        if (!ok || res !== expv) begin
            n_fail++;
            $display("FAIL sub_model: got %h expected %h ok=%0d", res, expv, ok);
        end
        n_checks++;
        if ({res[12:5], res[3], res[0]} !== EXP_SUB) begin
            n_fail++;
            $display("FAIL sub_05_07 {y,ovf,lt}: got %h expected %h", {res[12:5], res[3], res[0]}, EXP_SUB);
        end

        send_one(8'h5A, 8'h5A, ALU_AND, 1'b0, res, expv, ok);
        n_checks++;
        if (!ok || res !== expv) begin
            n_fail++;
            $display("FAIL and_model: got %h expected %h ok=%0d", res, expv, ok);
        end
        n_checks++;
        if ({res[12:5], res[1], res[4]} !== {8'h00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL and_5A_oe0 {y,eq,par}: got %h expected %h", {res[12:5], res[1], res[4]},
                     {8'h00, 1'b1, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int n   = 0;
        int ir_low = 0;
        clear_queues();
        out_ready = 1'b1;
        rand_beat();
        in_valid = 1'b1;
        while (acc < 8 && n < 100) begin
            tick();
            n++;
            if (!last_in_ready) ir_low++;
            if (last_in_fire) begin
                acc++;
                rand_beat();
            end
        end
        in_valid = 1'b0;
        n = 0;
        while (got_q.size() < 8 && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (acc !== 8 || got_q.size() !== 8 || exp_q.size() !== 8) begin
            n_fail++;
            $display("FAIL b2b_count: accepted %0d results %0d expected 8/8", acc, got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
            n_checks++;
            if (out_cyc_q[0] - in_cyc_q[0] !== 2) begin
                n_fail++;
                $display("FAIL b2b_latency: got %0d expected 2", out_cyc_q[0] - in_cyc_q[0]);
            end
            n_checks++;
            if (out_cyc_q[7] - out_cyc_q[0] !== 7) begin
                n_fail++;
                $display("FAIL b2b_consecutive: span %0d expected 7", out_cyc_q[7] - out_cyc_q[0]);
            end
        end
        n_checks++;
        if (ir_low !== 0) begin
            n_fail++;
            $display("FAIL b2b_in_ready: low on %0d cycles expected 0", ir_low);
        end
    endtask

    task automatic test_backpressure();
        int          acc = 0;
        int          n   = 0;
        int          unstable = 0;
        bit          seen = 0;
        logic [68:0] hold = '0;
        clear_queues();
        out_ready = 1'b0;
        rand_beat();
        in_valid = 1'b1;
        repeat (5) begin
            tick();
            if (last_in_fire) begin
                acc++;
                rand_beat();
            end
            if (last_out_valid) begin
                if (!seen) begin
                    hold = last_out;
                    seen = 1'b1;
                end else if (last_out !== hold) begin
                    unstable++;
                end
            end
        end
        n_checks++;
        if (acc !== 2) begin
            n_fail++;
            $display("FAIL bp_accepts: got %0d expected 2", acc);
        end
        n_checks++;
        if (last_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_in_ready: got %b expected 0", last_in_ready);
        end
        n_checks++;
        if (!seen || unstable !== 0) begin
            n_fail++;
            $display("FAIL bp_stable: seen %0d unstable %0d expected 1/0", seen, unstable);
        end
        out_ready = 1'b1;
        while (acc < 6 && n < 50) begin
            tick();
            n++;
            if (last_in_fire) begin
                acc++;
                rand_beat();
            end
        end
        in_valid = 1'b0;
        n = 0;
        while (got_q.size() < 6 && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (got_q.size() !== 6 || exp_q.size() !== 6) begin
            n_fail++;
            $display("FAIL bp_count: results %0d sent %0d expected 6/6", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL bp_result[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        int acc = 0;
        int n   = 0;
        clear_queues();
        out_ready = 1'b0;
        rand_beat();
        in_valid = 1'b1;
        while (acc < 2 && n < 10) begin
            tick();
            n++;
            if (last_in_fire) begin
                acc++;
                rand_beat();
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || acc !== 2) begin
            n_fail++;
            $display("FAIL rstmid_full: out_valid %b accepts %0d expected 1/2", out_valid, acc);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_in_ready_low: got %b expected 0", in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, y, in_ready} !== {1'b0, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_after {ov,y,ir}: got %h expected %h", {out_valid, y, in_ready},
                     {1'b0, 8'h00, 1'b1});
        end
        out_ready = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (got_q.size() !== 0) begin
            n_fail++;
            $display("FAIL rstmid_discard: got %0d results expected 0", got_q.size());
        end
    endtask

    task automatic test_random();
        int n = 0;
        clear_queues();
        rand_beat();
        repeat (300) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (last_in_fire) rand_beat();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (got_q.size() < exp_q.size() && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (got_q.size() !== exp_q.size() || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rand_count: results %0d sent %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_result[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic run16(input logic [15:0] ia, input logic [15:0] ib, input logic [1:0] iop,
                         input logic ioe, output logic [68:0] res, output bit ok);
        int n = 0;
        bit acc = 0;
        a16 = ia; b16 = ib; op16 = iop; oe16 = ioe;
        in_valid16  = 1'b1;
        out_ready16 = 1'b1;
        ok  = 1'b0;
        res = '0;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (out_valid16 && acc) begin
                res = pack16();
                ok  = 1'b1;
            end
            if (in_valid16 && in_ready16) acc = 1'b1;
            @(posedge clk);
            #1;
            if (acc) in_valid16 = 1'b0;
            n++;
        end
    endtask

    task automatic test_width16();
        logic [68:0] res;
        logic [68:0] expv;
        bit          ok;
        logic [15:0] ra, rb;
        logic [1:0]  rop;
        run16(16'hFFFF, 16'h00FF, ALU_XOR, 1'b1, res, ok);
        n_checks++;
        if (!ok || {res[20:5], res[3], res[4], res[2]} !== {16'hFF00, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL w16_xor {y,ovf,par,gt}: got %h expected %h ok=%0d",
                     {res[20:5], res[3], res[4], res[2]}, {16'hFF00, 1'b0, 1'b0, 1'b1}, ok);
        end
        for (int i = 0; i < 6; i++) begin
            ra  = 16'($urandom);
            rb  = (i == 0) ? ra : 16'($urandom);
            rop = 2'(i % 4);
            run16(ra, rb, rop, 1'b1, res, ok);
            expv = ref_model(16, {48'd0, ra}, {48'd0, rb}, rop, 1'b1);
            n_checks++;
            if (!ok || res !== expv) begin
                n_fail++;
                $display("FAIL w16_rand[%0d]: got %h expected %h ok=%0d", i, res, expv, ok);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; op = ALU_ADD; oe = 1'b0; out_ready = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; op16 = ALU_ADD; oe16 = 1'b0; out_ready16 = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        test_width16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
